// File: rtl/sdram_pkg.sv
// Shared types and helpers for the SDRAM burst writer slice.
// Holds the writer FSM encoding and the burst-legality rule.
package sdram_pkg;

   typedef enum logic [2:0] {
      IDLE,
      CHECK,
      FILL,
      BURST,
      DONE
   } bw_state_t;

   localparam int SDRAM_PAGE     = 256;
   localparam int SDRAM_MAX_PAGE = 16384;

   // Bursts the controller accepts: 1, 2, 4, 8 beats or one full page.
   function automatic logic legal_burst(input logic [15:0] bc);
      return (bc == 16'd1) || (bc == 16'd2) || (bc == 16'd4) || (bc == 16'd8) ||
             (bc == 16'(SDRAM_PAGE));
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with a first-word-fall-through head.
// Push while full is taken only when a pop frees the slot in the same cycle.
module sync_fifo #(
   parameter int DATA_W = 16,
   parameter int DEPTH  = 256
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   push,
   input  logic                   pop,
   input  logic [DATA_W-1:0]      din,
   output logic [DATA_W-1:0]      dout,
   output logic [$clog2(DEPTH):0] count,
   output logic                   full,
   output logic                   empty
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]     count_q, count_d;
   logic              do_push, do_pop;

   always_comb begin
      do_pop   = pop && (count_q != '0);
      do_push  = push && ((count_q != CW'(DEPTH)) || do_pop);
      wr_ptr_d = wr_ptr_q + AW'(do_push);
      rd_ptr_d = rd_ptr_q + AW'(do_pop);
      count_d  = count_q + CW'(do_push) - CW'(do_pop);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // NOTE: the storage array is not reset; pointers and count alone say which entries are valid.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= din;
   end

   assign dout  = mem_q[rd_ptr_q];
   assign count = count_q;
   assign full  = (count_q == CW'(DEPTH));
   assign empty = (count_q == '0);

endmodule

// File: rtl/sdram_burst_writer.sv
// Avalon-MM burst write master: buffers a word stream and writes a commanded
// transfer as fixed-size bursts, never starting a burst without its full data.
module sdram_burst_writer
   import sdram_pkg::*;
#(
   parameter int ADDR_W     = 23,
   parameter int DATA_W     = 16,
   parameter int BC_W       = 9,
   parameter int FIFO_DEPTH = 256
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cmd_start,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [15:0]       cmd_len,
   input  logic [BC_W-1:0]   cmd_burst,
   output logic              busy,
   output logic              done,
   output logic              err,
   input  logic [DATA_W-1:0] s_data,
   input  logic              s_valid,
   output logic              s_ready,
   output logic [ADDR_W-1:0] avm_address,
   output logic [BC_W-1:0]   avm_burstcount,
   output logic [DATA_W-1:0] avm_writedata,
   output logic              avm_write,
   output logic [1:0]        avm_byteenable,
   input  logic              avm_waitrequest
);

   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

   bw_state_t         state_q, state_d;
   logic [ADDR_W-1:0] avm_address_q, avm_address_d;
   logic [BC_W-1:0]   avm_burstcount_q, avm_burstcount_d;
   logic [BC_W-1:0]   burst_q, burst_d;
   logic [BC_W-1:0]   beats_q, beats_d;
   logic [BC_W-1:0]   blen;
   logic [15:0]       remaining_q, remaining_d;
   logic              avm_write_q, avm_write_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              err_q, err_d;
   logic              bad_q, bad_d;
   logic              cmd_ok;

   logic [CNT_W-1:0]  fifo_count;
   logic [DATA_W-1:0] fifo_dout;
   logic              fifo_full, fifo_empty, fifo_push, fifo_pop, accept;

   assign cmd_ok    = legal_burst(16'(cmd_burst)) && !cmd_addr[0];
   assign accept    = avm_write_q && !avm_waitrequest;
   assign fifo_push = s_valid && !fifo_full;
   assign fifo_pop  = accept && !fifo_empty;

   sync_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (fifo_push),
      .pop   (fifo_pop),
      .din   (s_data),
      .dout  (fifo_dout),
      .count (fifo_count),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   always_comb begin
      // NOTE: every _d defaults to its _q (pulses to 0) before the case so no latch is inferred.
      state_d          = state_q;
      avm_address_d    = avm_address_q;
      avm_burstcount_d = avm_burstcount_q;
      avm_write_d      = avm_write_q;
      burst_d          = burst_q;
      beats_d          = beats_q;
      remaining_d      = remaining_q;
      bad_d            = bad_q;
      busy_d           = busy_q;
      done_d           = 1'b0;
      err_d            = 1'b0;
      blen             = (remaining_q < 16'(burst_q)) ? BC_W'(remaining_q) : burst_q;

      case (state_q)
         IDLE: begin
            if (cmd_start) begin
               avm_address_d = cmd_addr;
               remaining_d   = cmd_len;
               burst_d       = cmd_burst;
               bad_d         = !cmd_ok;
               busy_d        = cmd_ok;
               state_d       = CHECK;
            end
         end
         CHECK: begin
            if (bad_q) begin
               err_d   = 1'b1;
               state_d = IDLE;
            end else if (remaining_q == 16'd0) begin
               state_d = DONE;
            end else begin
               state_d = FILL;
            end
         end
         FILL: begin
            // Wait for the whole burst to be buffered so beats never bubble.
            if (fifo_count >= CNT_W'(blen)) begin
               avm_burstcount_d = blen;
               beats_d          = blen;
               avm_write_d      = 1'b1;
               state_d          = BURST;
            end
         end
         BURST: begin
            if (accept) begin
               remaining_d = remaining_q - 16'd1;
               beats_d     = beats_q - BC_W'(1);
               if (beats_q == BC_W'(1)) begin
                  avm_write_d   = 1'b0;
                  avm_address_d = avm_address_q + (ADDR_W'(avm_burstcount_q) << 1);
                  state_d       = (remaining_q == 16'd1) ? DONE : FILL;
               end
            end
         end
         DONE: begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q          <= IDLE;
         avm_address_q    <= '0;
         avm_burstcount_q <= '0;
         avm_write_q      <= 1'b0;
         burst_q          <= '0;
         beats_q          <= '0;
         remaining_q      <= '0;
         bad_q            <= 1'b0;
         busy_q           <= 1'b0;
         done_q           <= 1'b0;
         err_q            <= 1'b0;
      end else begin
         state_q          <= state_d;
         avm_address_q    <= avm_address_d;
         avm_burstcount_q <= avm_burstcount_d;
         avm_write_q      <= avm_write_d;
         burst_q          <= burst_d;
         beats_q          <= beats_d;
         remaining_q      <= remaining_d;
         bad_q            <= bad_d;
         busy_q           <= busy_d;
         done_q           <= done_d;
         err_q            <= err_d;
      end
   end

   assign busy           = busy_q;
   assign done           = done_q;
   assign err            = err_q;
   assign s_ready        = !fifo_full;
   assign avm_address    = avm_address_q;
   assign avm_burstcount = avm_burstcount_q;
   assign avm_write      = avm_write_q;
   assign avm_writedata  = avm_write_q ? fifo_dout : '0;
   assign avm_byteenable = 2'b11;

endmodule

// File: tb/tb_sdram_burst_writer.sv
// Self-checking bench for sdram_burst_writer: a command table run against a
// burst/data scoreboard, plus hand sequences for wrap, reset and zero-length.
module tb_sdram_burst_writer;

   typedef struct packed {
      logic [22:0] addr;
      logic [15:0] len;
      logic [8:0]  burst;
      logic        stall;
      logic        restart;
      logic        exp_err;
   } vec_t;

   typedef struct packed {
      logic [22:0] addr;
      logic [8:0]  bc;
      logic [15:0] data;
   } beat_t;

   logic        clk;
   logic        reset;
   logic        cmd_start;
   logic [22:0] cmd_addr;
   logic [15:0] cmd_len;
   logic [8:0]  cmd_burst;
   logic        busy, done, err;
   logic [15:0] s_data;
   logic        s_valid, s_ready;
   logic [22:0] avm_address;
   logic [8:0]  avm_burstcount;
   logic [15:0] avm_writedata;
   logic        avm_write;
   logic [1:0]  avm_byteenable;
   logic        avm_waitrequest;

   int          n_cmp = 0;
   int          n_bad = 0;
   int          n_done, n_err, writes_seen;
   logic        busy_seen;
   logic        stall_mode = 1'b0;
   logic        prev_write = 1'b0;
   logic [22:0] prev_addr;
   logic [8:0]  prev_bc;
   logic [15:0] word_ctr = 16'd0;
   logic [15:0] exp_fifo[$];
   beat_t       beat_q[$];
   vec_t        vecs[8];

   sdram_burst_writer dut (
      .clk             (clk),
      .reset           (reset),
      .cmd_start       (cmd_start),
      .cmd_addr        (cmd_addr),
      .cmd_len         (cmd_len),
      .cmd_burst       (cmd_burst),
      .busy            (busy),
      .done            (done),
      .err             (err),
      .s_data          (s_data),
      .s_valid         (s_valid),
      .s_ready         (s_ready),
      .avm_address     (avm_address),
      .avm_burstcount  (avm_burstcount),
      .avm_writedata   (avm_writedata),
      .avm_write       (avm_write),
      .avm_byteenable  (avm_byteenable),
      .avm_waitrequest (avm_waitrequest)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Observe the bus just before the edge, advance one clock, then update waitrequest.
   task automatic tick();
      if (avm_write) begin
         writes_seen++;
         if (prev_write) begin
            check("addr_hold", 32'(avm_address), 32'(prev_addr));
            check("bc_hold", 32'(avm_burstcount), 32'(prev_bc));
         end
         if (!avm_waitrequest) beat_q.push_back({avm_address, avm_burstcount, avm_writedata});
      end
      prev_write = avm_write;
      prev_addr  = avm_address;
      prev_bc    = avm_burstcount;
      if (done) n_done++;
      if (err) n_err++;
      if (busy) busy_seen = 1'b1;
      @(posedge clk);
      #1;
      avm_waitrequest = stall_mode ? ~avm_waitrequest : 1'b0;
   endtask

   task automatic clear_obs();
      beat_q.delete();
      n_done      = 0;
      n_err       = 0;
      writes_seen = 0;
      busy_seen   = 1'b0;
   endtask

   task automatic push_words(input int n);
      int   got = 0;
      logic acc;
      for (int c = 0; c < n + 50 && got < n; c++) begin
         s_valid = 1'b1;
         s_data  = word_ctr;
         acc     = s_ready;
         tick();
         if (acc) begin
            exp_fifo.push_back(word_ctr);
            word_ctr++;
            got++;
         end
      end
      s_valid = 1'b0;
   endtask

   // Reference: beat i belongs to the burst starting at floor(i/burst)*burst.
   task automatic verify_beats(input logic [22:0] addr, input int len, input int burst);
      int          base, bc;
      logic [22:0] ea;
      logic [15:0] ed;
      check("beat_count", 32'(beat_q.size()), 32'(len));
      for (int i = 0; i < beat_q.size() && i < len; i++) begin
         base = (i / burst) * burst;
         bc   = (len - base < burst) ? len - base : burst;
         ea   = addr + 23'(2 * base);
         ed   = (exp_fifo.size() > 0) ? exp_fifo.pop_front() : 16'hDEAD;
         check("beat_addr", 32'(beat_q[i].addr), 32'(ea));
         check("beat_bc", 32'(beat_q[i].bc), 32'(bc));
         check("beat_data", 32'(beat_q[i].data), 32'(ed));
      end
   endtask

   task automatic pulse_cmd(input logic [22:0] a, input logic [15:0] l, input logic [8:0] b);
      cmd_addr  = a;
      cmd_len   = l;
      cmd_burst = b;
      cmd_start = 1'b1;
      tick();
      cmd_start = 1'b0;
   endtask

   task automatic run_vec(input vec_t v);
      if (!v.exp_err) push_words(int'(v.len));
      clear_obs();
      stall_mode = v.stall;
      pulse_cmd(v.addr, v.len, v.burst);
      for (int c = 0; c < 3000 && n_done == 0 && n_err == 0; c++) begin
         cmd_start = v.restart && (c == 5);
         if (cmd_start) begin
            cmd_addr  = 23'h001001;
            cmd_len   = 16'd1;
            cmd_burst = 9'd1;
         end
         tick();
      end
      cmd_start  = 1'b0;
      stall_mode = 1'b0;
      repeat (3) tick();
      check("err_pulses", 32'(n_err), 32'(v.exp_err));
      check("done_pulses", 32'(n_done), 32'(!v.exp_err));
      check("busy_seen", 32'(busy_seen), 32'(!v.exp_err));
      if (v.exp_err) check("err_no_write", 32'(writes_seen), 32'd0);
      verify_beats(v.addr, v.exp_err ? 0 : int'(v.len), int'(v.burst));
   endtask

   initial begin
      vec_t fresh;
      int   pushed;
      logic acc;

      //              addr         len     burst  stall restart err
      vecs[0] = {23'h000000, 16'd16, 9'd8,   1'b0, 1'b1, 1'b0};
      vecs[1] = {23'h000000, 16'd10, 9'd4,   1'b1, 1'b0, 1'b0};
      vecs[2] = {23'h000100, 16'd3,  9'd3,   1'b0, 1'b0, 1'b1};
      vecs[3] = {23'h000001, 16'd4,  9'd4,   1'b0, 1'b0, 1'b1};
      vecs[4] = {23'h000200, 16'd5,  9'd2,   1'b1, 1'b0, 1'b0};
      vecs[5] = {23'h000040, 16'd1,  9'd1,   1'b0, 1'b0, 1'b0};
      vecs[6] = {23'h7FFFF0, 16'd16, 9'd8,   1'b0, 1'b0, 1'b0};
      vecs[7] = {23'h000010, 16'd0,  9'd8,   1'b0, 1'b0, 1'b0};

      reset           = 1'b1;
      cmd_start       = 1'b0;
      cmd_addr        = '0;
      cmd_len         = '0;
      cmd_burst       = '0;
      s_data          = '0;
      s_valid         = 1'b0;
      avm_waitrequest = 1'b0;
      clear_obs();
      tick();
      tick();
      check("rst_write", 32'(avm_write), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_err", 32'(err), 32'd0);
      check("rst_addr", 32'(avm_address), 32'd0);
      check("rst_bc", 32'(avm_burstcount), 32'd0);
      check("rst_wdata", 32'(avm_writedata), 32'd0);
      check("rst_ready", 32'(s_ready), 32'd1);
      check("byteenable", 32'(avm_byteenable), 32'd3);
      reset = 1'b0;
      tick();

      for (int i = 0; i < 8; i++) run_vec(vecs[i]);

      // Zero length: start edge -> CHECK -> DONE, done visible on the third edge.
      clear_obs();
      pulse_cmd(23'h000020, 16'd0, 9'd4);
      check("len0_done_e0", 32'(done), 32'd0);
      check("len0_busy_e0", 32'(busy), 32'd1);
      tick();
      check("len0_done_e1", 32'(done), 32'd0);
      tick();
      check("len0_done_e2", 32'(done), 32'd1);
      check("len0_busy_e2", 32'(busy), 32'd0);
      tick();
      check("len0_done_e3", 32'(done), 32'd0);
      check("len0_no_write", 32'(writes_seen), 32'd0);

      // Full-page burst streamed after the start; must wait for all 256 words, then wrap.
      clear_obs();
      pulse_cmd(23'h7FFE00, 16'd256, 9'd256);
      pushed = 0;
      for (int c = 0; c < 2000 && n_done == 0; c++) begin
         s_valid = (pushed < 256);
         s_data  = word_ctr;
         acc     = s_valid && s_ready;
         if (pushed < 256 && avm_write) check("early_write", 32'(avm_write), 32'd0);
         tick();
         if (acc) begin
            exp_fifo.push_back(word_ctr);
            word_ctr++;
            pushed++;
            if (pushed == 256) begin
               check("full_ready", 32'(s_ready), 32'd0);
               check("full_no_write", 32'(avm_write), 32'd0);
            end
         end
      end
      s_valid = 1'b0;
      repeat (2) tick();
      check("page_done", 32'(n_done), 32'd1);
      verify_beats(23'h7FFE00, 256, 256);
      check("wrap_addr", 32'(avm_address), 32'd0);
      check("page_ready", 32'(s_ready), 32'd1);

      // Reset during beat 3 of an 8-beat burst.
      push_words(8);
      clear_obs();
      pulse_cmd(23'h000300, 16'd8, 9'd8);
      for (int c = 0; c < 50 && !avm_write; c++) tick();
      check("rst_burst_started", 32'(avm_write), 32'd1);
      tick();
      tick();
      reset = 1'b1;
      #1;
      check("rst_mid_write", 32'(avm_write), 32'd0);
      check("rst_mid_ready", 32'(s_ready), 32'd1);
      check("rst_mid_busy", 32'(busy), 32'd0);
      tick();
      reset = 1'b0;
      exp_fifo.delete();
      clear_obs();
      repeat (3) tick();
      check("rst_no_done", 32'(n_done), 32'd0);
      fresh = {23'h000400, 16'd8, 9'd8, 1'b0, 1'b0, 1'b0};
      run_vec(fresh);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
